// File: rtl/text_console_ctrl.sv
// Console writer for the 80x30 text RAM: cursor tracking, CR/LF/BS handling,
// row/screen clears, and RAM-port sharing with video reads (writes only in blanking).
module text_console_ctrl #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_char,
    output logic              in_ready,
    input  logic              clear,
    input  logic              blank_b,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_wren,
    output logic [6:0]        cursor_x,
    output logic [4:0]        cursor_y,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR_ROW, CLEAR_ALL} state_t;

    state_t            state_q, state_d;
    logic [6:0]        cx_q, cx_d;
    logic [4:0]        cy_q, cy_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [6:0]        col_q, col_d;
    logic              wren;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] y, input logic [6:0] x);
        return ADDR_W'(y) * ADDR_W'(COLS) + ADDR_W'(x);
    endfunction

    function automatic logic [4:0] next_row(input logic [4:0] y);
        return (y == 5'(ROWS - 1)) ? 5'd0 : y + 5'd1;
    endfunction

    assign wren     = (state_q != IDLE) && !blank_b;
    assign in_ready = (state_q == IDLE) && !clear && !pend_q;
    assign busy     = (state_q != IDLE);
    assign ram_wren = wren;
    assign ram_addr = wren ? waddr_q : vga_addr;
    assign ram_data = (wren && state_q == WRITE) ? wdata_q : 8'h00;
    assign cursor_x = cx_q;
    assign cursor_y = cy_q;

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        pend_d  = pend_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        col_d   = col_q;
        if (clear && state_q != IDLE) pend_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (clear || pend_q) begin
                    state_d = CLEAR_ALL;
                    pend_d  = 1'b0;
                    waddr_d = '0;
                end else if (in_valid) begin
                    if (in_char >= 8'h20 && in_char <= 8'h7E) begin
                        waddr_d = cell_addr(cy_q, cx_q);
                        wdata_d = in_char + 8'd1;
                        state_d = WRITE;
                    end else if (in_char == 8'h0A) begin
                        cx_d    = '0;
                        cy_d    = next_row(cy_q);
                        waddr_d = cell_addr(next_row(cy_q), 7'd0);
                        col_d   = '0;
                        state_d = CLEAR_ROW;
                    end else if (in_char == 8'h0D) begin
                        cx_d = '0;
                    end else if (in_char == 8'h08 && cx_q != 7'd0) begin
                        cx_d    = cx_q - 7'd1;
                        waddr_d = cell_addr(cy_q, cx_q - 7'd1);
                        wdata_d = 8'h00;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                // Printables are stored as c+1, never zero, so zero marks a backspace erase.
                if (wren) begin
                    if (wdata_q == 8'h00) begin
                        state_d = IDLE;
                    end else if (cx_q < 7'(COLS - 1)) begin
                        cx_d    = cx_q + 7'd1;
                        state_d = IDLE;
                    end else begin
                        cx_d    = '0;
                        cy_d    = next_row(cy_q);
                        waddr_d = cell_addr(next_row(cy_q), 7'd0);
                        col_d   = '0;
                        state_d = CLEAR_ROW;
                    end
                end
            end
            CLEAR_ROW: begin
                if (wren) begin
                    if (col_q == 7'(COLS - 1)) begin
                        state_d = IDLE;
                    end else begin
                        col_d   = col_q + 7'd1;
                        waddr_d = waddr_q + ADDR_W'(1);
                    end
                end
            end
            CLEAR_ALL: begin
                if (wren) begin
                    if (waddr_q == ADDR_W'(COLS * ROWS - 1)) begin
                        cx_d    = '0;
                        cy_d    = '0;
                        state_d = IDLE;
                    end else begin
                        waddr_d = waddr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            pend_q  <= pend_d;
        end
    end

    // Write address, data and column counter are only meaningful while a write is pending.
    always_ff @(posedge clk) begin
        waddr_q <= waddr_d;
        wdata_q <= wdata_d;
        col_q   <= col_d;
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Self-checking bench for text_console_ctrl: directed scenarios plus random
// character streams compared against a queue-based model of expected RAM writes.
module tb_text_console_ctrl;

    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam int AW   = 12;

    logic          clk = 0;
    logic          reset = 1;
    logic          in_valid = 0;
    logic [7:0]    in_char = 0;
    logic          in_ready;
    logic          clear = 0;
    logic          blank_b = 0;
    logic [AW-1:0] vga_addr = 0;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_data;
    logic          ram_wren;
    logic [6:0]    cursor_x;
    logic [4:0]    cursor_y;
    logic          busy;

    text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_char(in_char),
        .in_ready(in_ready), .clear(clear), .blank_b(blank_b), .vga_addr(vga_addr),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  mx = 0, my = 0;
    int  n_tests = 0, n_fail = 0, n_wr = 0;
    bit  mon_en = 0, rand_blank = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: expected write sequence and cursor, from the character rules.
    function automatic void push_wr(input int a, input int d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endfunction

    function automatic void model_adv_row();
        my = (my + 1) % ROWS;
        for (int c = 0; c < COLS; c++) push_wr(my * COLS + c, 0);
    endfunction

    function automatic void model_char(input int c);
        if (c >= 32 && c <= 126) begin
            push_wr(my * COLS + mx, c + 1);
            if (mx < COLS - 1) mx++;
            else begin mx = 0; model_adv_row(); end
        end else if (c == 10) begin
            mx = 0;
            model_adv_row();
        end else if (c == 13) begin
            mx = 0;
        end else if (c == 8 && mx > 0) begin
            mx--;
            push_wr(my * COLS + mx, 0);
        end
    endfunction

    function automatic void model_clear();
        for (int a = 0; a < COLS * ROWS; a++) push_wr(a, 0);
        mx = 0;
        my = 0;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        vga_addr = AW'($urandom);
        if (rand_blank) blank_b = ($urandom_range(0, 2) == 0);
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (ram_wren === 1'b1) begin
                n_wr++;
                if (exp_q.size() == 0) chk("unexpected_write", ram_addr, 32'hFFFF);
                else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", ram_addr, e.addr);
                    chk("wr_data", ram_data, e.data);
                end
            end else begin
                chk("rd_addr_pass", ram_addr, vga_addr);
                chk("rd_data_zero", ram_data, 0);
            end
        end
    end

    task automatic send(input logic [7:0] c);
        int n = 0;
        @(posedge clk);
        #1;
        in_valid = 1;
        in_char  = c;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 10000) break;
        end
        if (n > 10000) begin
            chk("ready_timeout", 0, 1);
            in_valid = 0;
        end else begin
            @(posedge clk);
            model_char(c);
            #1;
            in_valid = 0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        chk("idle_timeout", busy, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        exp_q.delete();
        mx = 0;
        my = 0;
    endtask

    task automatic chk_cursor(input string tag, input int x, input int y);
        chk({tag, "_x"}, cursor_x, x);
        chk({tag, "_y"}, cursor_y, y);
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1;
        clear = 1;
        @(posedge clk);
        model_clear();
        #1;
        clear = 0;
    endtask

    initial begin
        int w0, r;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        mon_en = 1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_wren", ram_wren, 0);
        chk("rst_ready", in_ready, 1);
        chk_cursor("rst", 0, 0);

        // 1: 'A' with exact latency
        @(posedge clk);
        #1;
        in_valid = 1;
        in_char = 8'h41;
        @(negedge clk);
        chk("t1_ready", in_ready, 1);
        @(posedge clk);
        model_char(8'h41);
        #1;
        in_valid = 0;
        @(negedge clk);
        chk("t1_wren", ram_wren, 1);
        chk("t1_addr", ram_addr, 0);
        chk("t1_data", ram_data, 8'h42);
        chk("t1_ready_lo", in_ready, 0);
        @(negedge clk);
        chk("t1_ready_back", in_ready, 1);
        chk("t1_wren_lo", ram_wren, 0);
        chk_cursor("t1", 1, 0);

        // 2: wrap at column 79 of row 2
        do_reset();
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 79; i++) send(8'($urandom_range(32, 126)));
        wait_idle(200);
        chk_cursor("t2_pre", 79, 2);
        send(8'h5A);
        @(negedge clk);
        chk("t2_addr", ram_addr, 239);
        chk("t2_data", ram_data, 8'h5B);
        wait_idle(500);
        chk_cursor("t2", 0, 3);
        chk("t2_busy", busy, 0);
        chk("t2_queue", exp_q.size(), 0);

        // 3: LF on last row wraps to the top
        do_reset();
        for (int i = 0; i < 29; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'($urandom_range(32, 126)));
        wait_idle(200);
        chk_cursor("t3_pre", 5, 29);
        w0 = n_wr;
        send(8'h0A);
        wait_idle(500);
        chk_cursor("t3", 0, 0);
        chk("t3_nwr", n_wr - w0, 80);
        chk("t3_queue", exp_q.size(), 0);

        // 4: backspace and dropped codes
        do_reset();
        send(8'h61);
        send(8'h62);
        send(8'h08);
        wait_idle(50);
        chk_cursor("t4_bs", 1, 0);
        send(8'h0D);
        wait_idle(50);
        w0 = n_wr;
        send(8'h08);
        repeat (4) @(negedge clk);
        chk("t4_bs0_nwr", n_wr - w0, 0);
        chk_cursor("t4_bs0", 0, 0);
        send(8'h07);
        repeat (4) @(negedge clk);
        chk("t4_bel_nwr", n_wr - w0, 0);
        chk("t4_queue", exp_q.size(), 0);

        // 5: write held off by active video
        do_reset();
        @(posedge clk);
        #1;
        blank_b = 1;
        send(8'h4B);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("t5_stall_wren", ram_wren, 0);
            chk("t5_stall_addr", ram_addr, vga_addr);
        end
        chk("t5_busy", busy, 1);
        @(posedge clk);
        #1;
        blank_b = 0;
        @(negedge clk);
        chk("t5_wren", ram_wren, 1);
        chk("t5_addr", ram_addr, 0);
        chk("t5_data", ram_data, 8'h4C);
        wait_idle(20);
        chk_cursor("t5", 1, 0);

        // 6: clear during a row clear, clear vs in_valid, reset mid clear
        do_reset();
        send(8'h31);
        wait_idle(20);
        w0 = n_wr;
        send(8'h0A);
        repeat (10) @(posedge clk);
        pulse_clear();
        wait_idle(3000);
        chk("t6_busy_gap", busy, 0);
        wait_idle(3000);
        chk_cursor("t6", 0, 0);
        chk("t6_nwr", n_wr - w0, 80 + 2400);
        chk("t6_queue", exp_q.size(), 0);
        @(posedge clk);
        #1;
        clear = 1;
        in_valid = 1;
        in_char = 8'h51;
        @(negedge clk);
        chk("t6_no_hs", in_ready, 0);
        @(posedge clk);
        model_clear();
        #1;
        clear = 0;
        in_valid = 0;
        wait_idle(3000);
        chk("t6b_queue", exp_q.size(), 0);
        pulse_clear();
        repeat (500) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        exp_q.delete();
        mx = 0;
        my = 0;
        @(negedge clk);
        chk("t6_rst_wren", ram_wren, 0);
        chk("t6_rst_ready", in_ready, 1);
        chk_cursor("t6_rst", 0, 0);

        // Random character stream with random blanking
        rand_blank = 1;
        for (int i = 0; i < 300; i++) begin
            if (i == 100 || i == 200) pulse_clear();
            r = $urandom_range(0, 99);
            if (r < 70)      send(8'($urandom_range(32, 126)));
            else if (r < 78) send(8'h0A);
            else if (r < 83) send(8'h0D);
            else if (r < 94) send(8'h08);
            else             send(8'($urandom_range(0, 31)));
        end
        wait_idle(10000);
        chk_cursor("rand", mx, my);
        chk("rand_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/text_console_ctrl.md
Name: text_console_ctrl

Overview:
- Console writer and single-port arbiter for the 80x30 text-buffer RAM that feeds the VGA character generator.
- Accepts a byte stream over a valid/ready handshake and tracks a cursor.
- Interprets CR, LF and BS, and performs row and full-screen clears.
- Shares the RAM port with the video read path by issuing writes only during blanking (blank_b low).

Parameters:
COLS, 80, characters per row
ROWS, 30, text rows
ADDR_W, 12, RAM address width (COLS*ROWS must be <= 2^ADDR_W)

Ports:
clk  in  1  system clock (the VGA pixel clock domain)
reset  in  1  synchronous, active-high reset
in_valid  in  1  input character valid
in_char  in  8  ASCII code
in_ready  out  1  controller can accept a character this cycle
clear  in  1  level request to clear the screen and home the cursor
blank_b  in  1  VGA blank_b; 0 = blanking, write slot available
vga_addr  in  ADDR_W  read address from the video generator
ram_addr  out  ADDR_W  address to the text RAM
ram_data  out  8  write data to the text RAM
ram_wren  out  1  text RAM write enable
cursor_x  out  7  current column, 0..COLS-1
cursor_y  out  5  current row, 0..ROWS-1
busy  out  1  high when not in IDLE

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; cursor_x=0, cursor_y=0; clear_pending=0; ram_wren=0; busy=0.
  - in_ready=1 in the first cycle after reset deasserts.
  - Reset mid-operation aborts immediately; RAM contents are left partially written.
- States: IDLE, WRITE, CLEAR_ROW, CLEAR_ALL.
- in_ready = (state==IDLE) && !clear && !clear_pending. A handshake completes on in_valid && in_ready.
- Write arbitration:
  - A write is pending in WRITE, CLEAR_ROW and CLEAR_ALL.
  - ram_wren = pending && !blank_b.
  - When ram_wren=1: ram_addr = write address. Otherwise ram_addr = vga_addr and ram_data = 0.
  - At most one write per cycle. A state advances only on cycles where ram_wren=1.
- Cell address = cursor_y*COLS + cursor_x, computed at ADDR_W bits with no overflow.
- Stored encoding: printable code c is stored as c+1 (8-bit); a blank cell stores 0x00.
- Accepted character handling in IDLE:
  - 0x20..0x7E: latch address and c+1, go to WRITE.
    - On the write cycle: if cursor_x < COLS-1, then cursor_x+1 and return to IDLE.
    - Else: cursor_x=0, advance the row, go to CLEAR_ROW.
  - 0x0A (LF): cursor_x=0, advance the row, go to CLEAR_ROW.
  - 0x0D (CR): cursor_x=0, stay in IDLE; no write.
  - 0x08 (BS):
    - If cursor_x>0: cursor_x-1, go to WRITE with data 0x00 at the new position, then IDLE. The cursor does not move again after this write.
    - If cursor_x=0: no-op.
  - Any other code: dropped, no write, stay in IDLE.
- Row advance: cursor_y = (cursor_y==ROWS-1) ? 0 : cursor_y+1, i.e. wrap to the top; no scrolling.
- CLEAR_ROW: writes 0x00 to the COLS cells of the new cursor_y, columns 0..COLS-1 in order, using an internal column counter (the cursor stays at column 0). Goes to IDLE after the write to column COLS-1.
- clear handling:
  - Sampled every cycle. If state!=IDLE, set clear_pending.
  - In IDLE with clear or clear_pending: go to CLEAR_ALL and clear clear_pending. clear takes priority over in_valid in the same cycle; no handshake occurs.
  - CLEAR_ALL writes 0x00 to addresses 0..COLS*ROWS-1 ascending, then sets cursor (0,0) and goes to IDLE.
  - A clear level still high at completion starts another CLEAR_ALL.
- Latency:
  - Printable accepted at cycle N with blank_b=0 continuously: ram_wren at N+1, in_ready=1 at N+2.
  - A full clear with blank_b=0 continuously takes 2400 write cycles plus 1 entry cycle.
- blank_b held high: pending writes stall indefinitely. The state, latched address/data and cursor are all held.

Test Plan:
1. Reset, blank_b=0, send 'A' (0x41) -> one ram_wren cycle with addr 0, data 0x42; cursor (1,0); in_ready back high 2 cycles after the handshake.
2. Cursor at (79,2), send 'Z' -> write addr 239 data 0x5B; then 80 zero writes to addrs 240..319; cursor (0,3); busy low after.
3. Cursor at (5,29), send LF -> cursor (0,0); zero writes to addrs 0..79 only.
4. Send 'a','b' then BS -> third write addr 1 data 0x00; cursor (1,0). BS at x=0 -> no write, cursor unchanged. 0x07 -> no write.
5. Toggle blank_b high for 100 cycles during a pending write -> ram_wren=0 and ram_addr==vga_addr throughout; write completes on the first blank_b=0 cycle with the same addr/data.
6. Assert clear during CLEAR_ROW -> row clear completes, then 2400 zero writes to addrs 0..2399, cursor (0,0). clear together with in_valid in IDLE -> no handshake. Reset mid-CLEAR_ALL -> next cycle ram_wren=0, cursor (0,0), in_ready=1.
